// File: rtl/i2s_rx_frontend.sv
// Slave I2S receiver: oversamples sclk/ws/data on clk, recovers 24-bit stereo words
// and presents the top OUT_W bits of each L/R pair with a one-clk vld strobe.
//
// state   | meaning
// SYNC_HI | unlocked, waiting for ws = 1 (right slot)
// SYNC_LO | waiting for ws fall; that srise is the delay bit
// LEFT    | shifting left-channel bits MSB-first
// WAIT_R  | left word done, skipping padding until ws rises
// RIGHT   | shifting right-channel bits MSB-first
// WAIT_L  | right word done, skipping padding until ws falls
module i2s_rx_frontend #(
  parameter int DATA_W = 24,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I2S_sclk,
  input  logic             I2S_ws,
  input  logic             I2S_data,
  output logic [OUT_W-1:0] lft_chnnl,
  output logic [OUT_W-1:0] rght_chnnl,
  output logic             vld,
  output logic             synced
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    SYNC_HI,
    SYNC_LO,
    LEFT,
    WAIT_R,
    RIGHT,
    WAIT_L
  } state_t;

  state_t             state;
  logic               sclk_s1, sclk_s2, sclk_s3;
  logic               ws_s1, ws_s2;
  logic               data_s1, data_s2;
  logic               srise;
  logic               commit;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  shift_nxt;
  logic [OUT_W-1:0]   left_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ws_s1   <= 1'b0;
      ws_s2   <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      sclk_s1 <= I2S_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ws_s1   <= I2S_ws;
      ws_s2   <= ws_s1;
      data_s1 <= I2S_data;
      data_s2 <= data_s1;
    end
  end

  assign srise     = sclk_s2 & ~sclk_s3;
  assign shift_nxt = {shift_q[DATA_W-2:0], data_s2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC_HI;
      bit_cnt    <= '0;
      shift_q    <= '0;
      left_hold  <= '0;
      commit     <= 1'b0;
      lft_chnnl  <= '0;
      rght_chnnl <= '0;
      vld        <= 1'b0;
      synced     <= 1'b0;
    end else begin
      vld    <= 1'b0;
      commit <= 1'b0;
      // srise never fires two clks in a row, so the shift register is stable here
      if (commit) begin
        lft_chnnl  <= left_hold;
        rght_chnnl <= shift_q[DATA_W-1 -: OUT_W];
        vld        <= 1'b1;
        synced     <= 1'b1;
      end
      if (srise) begin
        case (state)
          SYNC_HI: if (ws_s2) state <= SYNC_LO;
          SYNC_LO: begin
            if (!ws_s2) begin
              state   <= LEFT;
              bit_cnt <= '0;
            end
          end
          LEFT: begin
            if (ws_s2) begin
              state  <= SYNC_HI;
              synced <= 1'b0;
            end else begin
              shift_q <= shift_nxt;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                left_hold <= shift_nxt[DATA_W-1 -: OUT_W];
                state     <= WAIT_R;
              end
            end
          end
          WAIT_R: begin
            if (ws_s2) begin
              state   <= RIGHT;
              bit_cnt <= '0;
            end
          end
          RIGHT: begin
            if (!ws_s2) begin
              state  <= SYNC_HI;
              synced <= 1'b0;
            end else begin
              shift_q <= shift_nxt;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                commit <= 1'b1;
                state  <= WAIT_L;
              end
            end
          end
          WAIT_L: begin
            if (!ws_s2) begin
              state   <= LEFT;
              bit_cnt <= '0;
            end
          end
          default: state <= SYNC_HI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: drives I2S frames from tasks and checks
// recovered samples, vld pulses, lock status and latency against hand-computed values.
module tb_i2s_rx_frontend;

  localparam int DATA_W = 24;
  localparam int OUT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sclk, ws, data;
  logic [OUT_W-1:0] lft, rght;
  logic             vld, synced;

  int n_checks = 0;
  int n_fail   = 0;
  int half     = 5;
  int cyc      = 0;
  int vld_cnt  = 0;
  int wide_cnt = 0;
  int vld_cyc  = 0;
  int rise_cyc = 0;
  int vc;
  logic prev_vld = 1'b0;
  logic [OUT_W-1:0] cap_l = '0;
  logic [OUT_W-1:0] cap_r = '0;

  i2s_rx_frontend #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I2S_sclk   (sclk),
    .I2S_ws     (ws),
    .I2S_data   (data),
    .lft_chnnl  (lft),
    .rght_chnnl (rght),
    .vld        (vld),
    .synced     (synced)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (vld) begin
      vld_cnt++;
      cap_l   = lft;
      cap_r   = rght;
      vld_cyc = cyc;
      if (prev_vld) wide_cnt++;
    end
    prev_vld = vld;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit index 0 of a slot is the delay bit; indices 1..DATA_W carry the word MSB-first.
  task automatic send_bits(input logic ws_v, input logic [DATA_W-1:0] word,
                           input int from, input int to);
    for (int i = from; i < to; i++) begin
      sclk = 1'b0;
      ws   = ws_v;
      data = (i >= 1 && i <= DATA_W) ? word[DATA_W-i] : 1'b0;
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      if (ws_v && i == DATA_W) rise_cyc = cyc;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int slot);
    send_bits(1'b0, l, 0, slot);
    send_bits(1'b1, r, 0, slot);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    ws    = 1'b0;
    data  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lft", 32'(lft), 32'h0);
    chk("rst_rght", 32'(rght), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_synced", 32'(synced), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // two clean frames, 32-bit slots
    send_bits(1'b1, 24'h0, 0, 32);
    chk("pre_synced", 32'(synced), 32'h0);
    vc = vld_cnt;
    send_frame(24'h123456, 24'hABCDEF, 32);
    chk("f1_vld_cnt", 32'(vld_cnt - vc), 32'd1);
    chk("f1_lft", 32'(cap_l), 32'h1234);
    chk("f1_rght", 32'(cap_r), 32'hABCD);
    chk("f1_synced", 32'(synced), 32'h1);
    chk("f1_latency", 32'(vld_cyc - rise_cyc), 32'd4);
    send_frame(24'h123456, 24'hABCDEF, 32);
    chk("f2_vld_cnt", 32'(vld_cnt - vc), 32'd2);
    chk("f2_lft", 32'(lft), 32'h1234);
    chk("f2_rght", 32'(rght), 32'hABCD);

    // start mid-right-slot after a fresh reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vc = vld_cnt;
    send_bits(1'b1, 24'hFFFFFF, 5, 15);
    chk("mid_no_vld", 32'(vld_cnt - vc), 32'd0);
    send_frame(24'h00F00F, 24'h5A5A5A, 32);
    chk("mid_vld_cnt", 32'(vld_cnt - vc), 32'd1);
    chk("mid_lft", 32'(cap_l), 32'h00F0);
    chk("mid_rght", 32'(cap_r), 32'h5A5A);

    // sign extremes
    send_frame(24'h800000, 24'h7FFFFF, 32);
    chk("sign_lft", 32'(cap_l), 32'h8000);
    chk("sign_rght", 32'(cap_r), 32'h7FFF);

    // ws toggles after 10 left bits
    vc = vld_cnt;
    send_bits(1'b0, 24'hC3C3C3, 0, 11);
    send_bits(1'b1, 24'h111111, 0, 32);
    chk("ferr_synced", 32'(synced), 32'h0);
    chk("ferr_no_vld", 32'(vld_cnt - vc), 32'd0);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 32);
    chk("relock_vld_cnt", 32'(vld_cnt - vc), 32'd1);
    chk("relock_lft", 32'(cap_l), 32'h0F0F);
    chk("relock_rght", 32'(cap_r), 32'hF0F0);
    chk("relock_synced", 32'(synced), 32'h1);

    // reset mid-right-slot
    vc = vld_cnt;
    send_bits(1'b0, 24'h13579B, 0, 32);
    send_bits(1'b1, 24'h2468AC, 0, 11);
    rst_n = 1'b0;
    #1;
    chk("mrst_lft", 32'(lft), 32'h0);
    chk("mrst_rght", 32'(rght), 32'h0);
    chk("mrst_synced", 32'(synced), 32'h0);
    chk("mrst_vld", 32'(vld), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bits(1'b1, 24'h2468AC, 11, 32);
    chk("mrst_no_vld", 32'(vld_cnt - vc), 32'd0);
    send_frame(24'h654321, 24'h0ABCDE, 32);
    chk("mrst_vld_cnt", 32'(vld_cnt - vc), 32'd1);
    chk("mrst_new_lft", 32'(cap_l), 32'h6543);
    chk("mrst_new_rght", 32'(cap_r), 32'h0ABC);

    // clk/sclk ratio 8: 32-bit slots work, 24-bit slots are framing errors
    half = 4;
    vc = vld_cnt;
    send_frame(24'h2468AC, 24'hFEDCBA, 32);
    chk("r8_vld_cnt", 32'(vld_cnt - vc), 32'd1);
    chk("r8_lft", 32'(cap_l), 32'h2468);
    chk("r8_rght", 32'(cap_r), 32'hFEDC);
    chk("r8_latency", 32'(vld_cyc - rise_cyc), 32'd4);
    vc = vld_cnt;
    send_frame(24'h111111, 24'h222222, 24);
    send_frame(24'h333333, 24'h444444, 24);
    chk("s24_no_vld", 32'(vld_cnt - vc), 32'd0);
    chk("s24_synced", 32'(synced), 32'h0);
    send_frame(24'hDEAD12, 24'hBEEF34, 32);
    chk("s24_recover_cnt", 32'(vld_cnt - vc), 32'd1);
    chk("s24_recover_lft", 32'(cap_l), 32'hDEAD);
    chk("s24_recover_rght", 32'(cap_r), 32'hBEEF);

    chk("vld_width", 32'(wide_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
